seg7_attempt_decoder: RTL and testbench

//  Receive side of the attempt-count display bus. Samples the two active-low 7-seg digit buses
//  (ones, tens), filters glitches and decodes each pattern back to BCD. Rebuilds the 0..99 attempt

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_digit_decode.sv | 29 ++
 rtl/seg7_attempt_decoder.sv | 147 ++++++++++++++
 tb/tb_seg7_attempt_decoder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the attempt-count display receiver: segment codes, event kinds,
// decoder states and the BCD-to-binary / change-classification helpers.
package seg7_pkg;

    // Active-low segment codes, bit0=a .. bit6=g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {EVT_INC, EVT_WRAP, EVT_CLEAR, EVT_JUMP} evt_kind_e;

    typedef enum logic [1:0] {WAIT_FIRST, LOCKED, FAULT} dec_state_e;

    // tens*10 + ones as shift-and-add; the result never exceeds 99
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return 7'({tens, 1'b0}) + {tens, 3'b000} + 7'(ones);
    endfunction

    function automatic evt_kind_e classify(input logic [6:0] old_v, input logic [6:0] new_v);
        if (new_v == old_v + 7'd1)
            return EVT_INC;
        else if (old_v == 7'd99 && new_v == 7'd0)
            return EVT_WRAP;
        else if (new_v == 7'd0)
            return EVT_CLEAR;
        else
            return EVT_JUMP;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational 7-segment (active-low) to BCD decoder; ok is low for any non-digit code,
// including blank.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       ok
);

    always_comb begin
        digit = 4'd0;
        ok    = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_attempt_decoder.sv
// Receive side of the attempt-count display bus: sync, glitch-filter, decode, classify changes.
// Optional STICKY_ERR_EN adds err_clr/err_sticky error latching.
module seg7_attempt_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_ones,
    input  logic [6:0] seg_tens,
    output logic [3:0] digit_ones,
    output logic [3:0] digit_tens,
    output logic [6:0] value,
    output logic       locked,
    output logic       bad_pattern,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_kind,
    output logic [6:0] evt_value,
    output logic       evt_drop
`ifdef STICKY_ERR_EN
    ,
    input  logic       err_clr,
    output logic       err_sticky
`endif
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [13:0]   sync1, sync2, prev;
    logic [CW-1:0] stable_cnt;
    logic          accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= {SEG_BLANK, SEG_BLANK};
            sync2      <= {SEG_BLANK, SEG_BLANK};
            prev       <= {SEG_BLANK, SEG_BLANK};
            stable_cnt <= '0;
        end else begin
            sync1 <= {seg_tens, seg_ones};
            sync2 <= sync1;
            prev  <= sync2;
            if (sync2 != prev)
                stable_cnt <= '0;
            else if (stable_cnt != CNT_MAX)
                stable_cnt <= stable_cnt + 1'b1;
        end
    end

    // One-cycle strobe on the counter's step into saturation
    assign accept = (sync2 == prev) && (stable_cnt == CNT_PRE);

    logic [3:0] dec_ones, dec_tens;
    logic       ok_ones, ok_tens, pair_ok;
    logic [6:0] new_value;

    seg7_digit_decode u_dec_ones (.seg(prev[6:0]),  .digit(dec_ones), .ok(ok_ones));
    seg7_digit_decode u_dec_tens (.seg(prev[13:7]), .digit(dec_tens), .ok(ok_tens));

    assign pair_ok   = ok_ones && ok_tens;
    assign new_value = bcd_to_bin(dec_tens, dec_ones);

    dec_state_e state, state_n;
    logic       load_val, set_bad, clr_bad, evt_new;
    evt_kind_e  evt_kind_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_FIRST;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        load_val   = 1'b0;
        set_bad    = 1'b0;
        clr_bad    = 1'b0;
        evt_new    = 1'b0;
        evt_kind_n = EVT_JUMP;
        if (accept) begin
            if (!pair_ok) begin
                set_bad = 1'b1;
                if (state == LOCKED) state_n = FAULT;
            end else begin
                load_val = 1'b1;
                clr_bad  = 1'b1;
                state_n  = LOCKED;
                if (state == WAIT_FIRST) begin
                    evt_new    = 1'b1;
                    evt_kind_n = (new_value == 7'd0) ? EVT_CLEAR : EVT_JUMP;
                end else if (new_value != value) begin
                    evt_new    = 1'b1;
                    evt_kind_n = classify(value, new_value);
                end
            end
        end
    end

    // Event handshake: an event transfers on any edge where evt_valid && evt_ready; kind/value
    // are held while valid && !ready, and a newer event overwrites a stalled one (evt_drop).
    logic overwrite;
    assign overwrite = evt_new && evt_valid && !evt_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_ones  <= '0;
            digit_tens  <= '0;
            value       <= '0;
            locked      <= 1'b0;
            bad_pattern <= 1'b0;
            evt_valid   <= 1'b0;
            evt_kind    <= '0;
            evt_value   <= '0;
            evt_drop    <= 1'b0;
        end else begin
            if (load_val) begin
                digit_ones <= dec_ones;
                digit_tens <= dec_tens;
                value      <= new_value;
                locked     <= 1'b1;
            end
            if (set_bad)      bad_pattern <= 1'b1;
            else if (clr_bad) bad_pattern <= 1'b0;
            evt_drop <= overwrite;
            if (evt_new) begin
                evt_valid <= 1'b1;
                evt_kind  <= evt_kind_n;
                evt_value <= new_value;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

`ifdef STICKY_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           err_sticky <= 1'b0;
        else if ((accept && !pair_ok) || overwrite) err_sticky <= 1'b1;
        else if (err_clr)                    err_sticky <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_seg7_attempt_decoder.sv
// Bench for seg7_attempt_decoder: directed scenarios plus randomized pattern sequences checked
// against an integer-level model of the display count and event register.
module tb_seg7_attempt_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_ones, seg_tens;
    logic [3:0] digit_ones, digit_tens;
    logic [6:0] value;
    logic       locked, bad_pattern, evt_valid, evt_ready, evt_drop;
    logic [1:0] evt_kind;
    logic [6:0] evt_value;
`ifdef STICKY_ERR_EN
    logic       err_clr = 1'b0;
    logic       err_sticky;
`endif

    seg7_attempt_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .seg_ones(seg_ones), .seg_tens(seg_tens),
        .digit_ones(digit_ones), .digit_tens(digit_tens), .value(value), .locked(locked),
        .bad_pattern(bad_pattern), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_kind(evt_kind), .evt_value(evt_value), .evt_drop(evt_drop)
`ifdef STICKY_ERR_EN
        , .err_clr(err_clr), .err_sticky(err_sticky)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int drop_seen = 0;

    always @(posedge clk) if (evt_drop === 1'b1) drop_seen++;

    // Reference model: the count as an integer and a one-slot event mailbox
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
    logic       m_locked, m_bad, m_evt_valid;
    int         m_value, m_do, m_dt, m_kind, m_evt_value;
    int         exp_drops = 0;
    logic [6:0] cur_o, cur_t;

    function automatic int seg_to_digit(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_bad = 0; m_evt_valid = 0;
        m_value = 0; m_do = 0; m_dt = 0; m_kind = 0; m_evt_value = 0;
    endtask

    task automatic model_emit(input int k, input int v);
        if (m_evt_valid) exp_drops++;
        m_evt_valid = 1; m_kind = k; m_evt_value = v;
    endtask

    task automatic model_accept(input logic [6:0] o, input logic [6:0] t);
        int d_o, d_t, nv;
        d_o = seg_to_digit(o);
        d_t = seg_to_digit(t);
        if (d_o < 0 || d_t < 0) begin
            m_bad = 1;
        end else begin
            nv = d_t * 10 + d_o;
            m_bad = 0;
            if (!m_locked)                      model_emit(nv == 0 ? 2 : 3, nv);
            else if (nv == m_value + 1)         model_emit(0, nv);
            else if (m_value == 99 && nv == 0)  model_emit(1, nv);
            else if (nv != m_value)             model_emit(nv == 0 ? 2 : 3, nv);
            m_locked = 1; m_value = nv; m_do = d_o; m_dt = d_t;
        end
    endtask

    task automatic apply(input logic [6:0] o, input logic [6:0] t);
        logic step;
        step = (o !== cur_o) || (t !== cur_t);
        seg_ones = o; seg_tens = t; cur_o = o; cur_t = t;
        repeat (S + 4) @(posedge clk);
        @(negedge clk);
        if (step) model_accept(o, t);
    endtask

    task automatic consume();
        @(negedge clk); evt_ready = 1'b1;
        @(posedge clk); @(negedge clk); evt_ready = 1'b0;
        m_evt_valid = 0;
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL consume: evt_valid got %b exp 0", evt_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; evt_ready = 1'b0;
        seg_ones = 7'h40; seg_tens = 7'h40; cur_o = 7'h40; cur_t = 7'h40;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({locked, bad_pattern, evt_valid, evt_drop, value, digit_ones, digit_tens, evt_kind, evt_value} !== 28'd0) begin
            errors++; $display("FAIL reset_outputs: got %h exp 0",
                {locked, bad_pattern, evt_valid, evt_drop, value, digit_ones, digit_tens, evt_kind, evt_value});
        end
        reset = 1'b0;
        repeat (S + 2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (locked !== 1'b0 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL early_accept: locked %b evt_valid %b exp 0 0", locked, evt_valid);
        end
        @(posedge clk); @(negedge clk);
        model_accept(7'h40, 7'h40);
        checks++;
        if (locked !== 1'b1 || value !== 7'd0 || evt_valid !== 1'b1 || evt_kind !== 2'(m_kind)) begin
            errors++; $display("FAIL first_accept: locked %b value %0d evt_valid %b kind %0d exp 1 0 1 %0d",
                locked, value, evt_valid, evt_kind, m_kind);
        end
        consume();
    endtask

    task automatic test_inc();
        apply(7'h00, 7'h40);
        consume();
        apply(7'h18, 7'h40);
        checks++;
        if (evt_valid !== 1'b1 || evt_kind !== 2'd0 || evt_value !== 7'd9 || digit_ones !== 4'd9) begin
            errors++; $display("FAIL inc_9: valid %b kind %0d value %0d ones %0d exp 1 0 9 9",
                evt_valid, evt_kind, evt_value, digit_ones);
        end
        consume();
        apply(7'h40, 7'h79);
        checks++;
        if (evt_kind !== 2'd0 || evt_value !== 7'd10 || value !== 7'd10 || digit_tens !== 4'd1) begin
            errors++; $display("FAIL inc_10: kind %0d evt_value %0d value %0d tens %0d exp 0 10 10 1",
                evt_kind, evt_value, value, digit_tens);
        end
        consume();
    endtask

    task automatic test_wrap_clear();
        apply(7'h18, 7'h18);
        consume();
        apply(7'h40, 7'h40);
        checks++;
        if (evt_valid !== 1'b1 || evt_kind !== 2'd1 || evt_value !== 7'd0) begin
            errors++; $display("FAIL wrap: valid %b kind %0d value %0d exp 1 1 0", evt_valid, evt_kind, evt_value);
        end
        consume();
        apply(7'h24, 7'h19);
        consume();
        apply(7'h40, 7'h40);
        checks++;
        if (evt_valid !== 1'b1 || evt_kind !== 2'd2 || evt_value !== 7'd0) begin
            errors++; $display("FAIL clear: valid %b kind %0d value %0d exp 1 2 0", evt_valid, evt_kind, evt_value);
        end
        consume();
    endtask

    task automatic test_glitch();
        int d0;
        d0 = drop_seen;
        for (int i = 0; i < 20; i++) begin
            seg_ones = (i % 2 == 0) ? 7'h79 : 7'h24;
            cur_o = seg_ones;
            repeat (2) @(negedge clk);
        end
        checks++;
        if (value !== 7'd0 || evt_valid !== 1'b0 || drop_seen !== d0 || bad_pattern !== 1'b0) begin
            errors++; $display("FAIL glitch: value %0d valid %b drops %0d bad %b exp 0 0 %0d 0",
                value, evt_valid, drop_seen, bad_pattern, d0);
        end
        apply(7'h40, 7'h40);
        checks++;
        if (value !== 7'd0 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL glitch_settle: value %0d valid %b exp 0 0", value, evt_valid);
        end
    endtask

    task automatic test_bad();
        apply(7'h24, 7'h19);
        consume();
        apply(7'h7F, 7'h19);
        checks++;
        if (bad_pattern !== 1'b1 || value !== 7'd42 || locked !== 1'b1 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL bad_blank: bad %b value %0d locked %b valid %b exp 1 42 1 0",
                bad_pattern, value, locked, evt_valid);
        end
        apply(7'h30, 7'h19);
        checks++;
        if (bad_pattern !== 1'b0 || value !== 7'd43 || evt_valid !== 1'b1 || evt_kind !== 2'd0 || evt_value !== 7'd43) begin
            errors++; $display("FAIL bad_recover: bad %b value %0d valid %b kind %0d ev %0d exp 0 43 1 0 43",
                bad_pattern, value, evt_valid, evt_kind, evt_value);
        end
        consume();
    endtask

    task automatic test_drop();
        int d0;
        d0 = drop_seen;
        apply(7'h12, 7'h19);
        apply(7'h02, 7'h19);
        checks++;
        if (drop_seen - d0 !== 1 || evt_value !== 7'd46 || evt_kind !== 2'd0 || drop_seen !== exp_drops) begin
            errors++; $display("FAIL drop: pulses %0d ev %0d kind %0d exp 1 46 0",
                drop_seen - d0, evt_value, evt_kind);
        end
`ifdef STICKY_ERR_EN
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++; $display("FAIL sticky_set: got %b exp 1", err_sticky);
        end
        err_clr = 1'b1; @(posedge clk); @(negedge clk); err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++; $display("FAIL sticky_clr: got %b exp 0", err_sticky);
        end
`endif
        consume();
    endtask

    task automatic test_back_to_back();
        apply(7'h12, 7'h79);
        seg_ones = 7'h02; cur_o = 7'h02;
        repeat (S + 2) @(posedge clk);
        @(negedge clk); evt_ready = 1'b1;
        @(posedge clk); @(negedge clk); evt_ready = 1'b0;
        m_evt_valid = 0;
        model_accept(7'h02, 7'h79);
        @(posedge clk); @(negedge clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_value !== 7'd16 || evt_kind !== 2'd0 || drop_seen !== exp_drops) begin
            errors++; $display("FAIL back_to_back: valid %b ev %0d kind %0d drops %0d exp 1 16 0 %0d",
                evt_valid, evt_value, evt_kind, drop_seen, exp_drops);
        end
    endtask

    task automatic test_reset_mid();
        seg_ones = 7'h78; cur_o = 7'h78;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0 || locked !== 1'b0 || value !== 7'd0) begin
            errors++; $display("FAIL reset_mid: valid %b locked %b value %0d exp 0 0 0", evt_valid, locked, value);
        end
        reset = 1'b0;
        repeat (S + 4) @(posedge clk);
        @(negedge clk);
        model_reset();
        model_accept(7'h78, 7'h79);
        checks++;
        if (locked !== 1'b1 || value !== 7'd17 || evt_valid !== 1'b1 || evt_kind !== 2'd3 || evt_value !== 7'd17) begin
            errors++; $display("FAIL reset_reacquire: locked %b value %0d valid %b kind %0d ev %0d exp 1 17 1 3 17",
                locked, value, evt_valid, evt_kind, evt_value);
        end
        consume();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int sel, nv;
            logic [6:0] po, pt;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                po = 7'($urandom_range(0, 127));
                pt = seg_tab[$urandom_range(0, 9)];
            end else begin
                if (sel <= 3)      nv = (m_value + 1) % 100;
                else if (sel == 4) nv = 0;
                else if (sel == 5) nv = m_value;
                else               nv = $urandom_range(0, 99);
                po = seg_tab[nv % 10];
                pt = seg_tab[nv / 10];
            end
            apply(po, pt);
            checks++;
            if (value !== 7'(m_value) || digit_ones !== 4'(m_do) || digit_tens !== 4'(m_dt)) begin
                errors++; $display("FAIL rnd_value[%0d]: got %0d (%0d,%0d) exp %0d (%0d,%0d)",
                    i, value, digit_tens, digit_ones, m_value, m_dt, m_do);
            end
            checks++;
            if (locked !== m_locked || bad_pattern !== m_bad || evt_valid !== m_evt_valid) begin
                errors++; $display("FAIL rnd_flags[%0d]: locked %b bad %b valid %b exp %b %b %b",
                    i, locked, bad_pattern, evt_valid, m_locked, m_bad, m_evt_valid);
            end
            if (m_evt_valid) begin
                checks++;
                if (evt_kind !== 2'(m_kind) || evt_value !== 7'(m_evt_value)) begin
                    errors++; $display("FAIL rnd_event[%0d]: kind %0d ev %0d exp %0d %0d",
                        i, evt_kind, evt_value, m_kind, m_evt_value);
                end
            end
            checks++;
            if (drop_seen !== exp_drops) begin
                errors++; $display("FAIL rnd_drops[%0d]: got %0d exp %0d", i, drop_seen, exp_drops);
            end
            if ($urandom_range(0, 2) == 0) consume();
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_inc();
        test_wrap_clear();
        test_glitch();
        test_bad();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
